// File: rtl/ifmap_read_sched.sv
// Layer-level sequencer for the ifmap read path: configures the address
// generator once per layer, then gates its advance strobe block by block.
module ifmap_read_sched #(
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int BLK_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [8*BANK_ADDR_WIDTH-1:0] layer_cfg,
  input  logic [BLK_WIDTH-1:0]         num_blocks,
  input  logic                         bank_ready,
  input  logic                         stall,
  output logic                         gen_config_en,
  output logic [8*BANK_ADDR_WIDTH-1:0] gen_config_data,
  output logic                         gen_adr_en,
  output logic                         rd_valid,
  output logic                         bank_release,
  output logic                         busy,
  output logic                         done
);

  localparam int W  = BANK_ADDR_WIDTH;
  localparam int CW = 8 * BANK_ADDR_WIDTH;
  localparam int PW = 5 * BANK_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_WAIT_BANK,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cfg_q, cfg_d;
  logic [BLK_WIDTH-1:0] nblk_q, nblk_d;
  logic [BLK_WIDTH-1:0] blk_left_q, blk_left_d;
  logic [PW-1:0]        rpb_q, rpb_d;
  logic [PW-1:0]        rd_left_q, rd_left_d;
  logic                 rd_valid_q;
  logic                 issue;
  logic [PW-1:0]        ox0_x, oy0_x, fx_x, fy_x, ic1_x, rpb_calc;

  // Operands are widened first so the five-way product never truncates.
  assign ox0_x    = PW'(layer_cfg[8*W-1 -: W]);
  assign oy0_x    = PW'(layer_cfg[7*W-1 -: W]);
  assign fx_x     = PW'(layer_cfg[6*W-1 -: W]);
  assign fy_x     = PW'(layer_cfg[5*W-1 -: W]);
  assign ic1_x    = PW'(layer_cfg[W-1 -: W]);
  assign rpb_calc = ox0_x * oy0_x * fx_x * fy_x * ic1_x;

  assign issue = (state_q == S_RUN) && !stall;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_CONFIG;
      S_CONFIG: begin
        if (rpb_q == '0 || nblk_q == '0) state_d = S_DONE;
        else                             state_d = S_WAIT_BANK;
      end
      S_WAIT_BANK: if (bank_ready) state_d = S_RUN;
      S_RUN:       if (issue && rd_left_q == PW'(1)) state_d = S_DRAIN;
      S_DRAIN: begin
        if (blk_left_q > BLK_WIDTH'(1)) state_d = S_WAIT_BANK;
        else                            state_d = S_DONE;
      end
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_d      = cfg_q;
    nblk_d     = nblk_q;
    rpb_d      = rpb_q;
    blk_left_d = blk_left_q;
    rd_left_d  = rd_left_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_d  = layer_cfg;
          nblk_d = num_blocks;
          rpb_d  = rpb_calc;
        end
      end
      S_CONFIG: begin
        if (rpb_q != '0 && nblk_q != '0) begin
          blk_left_d = nblk_q;
          rd_left_d  = rpb_q;
        end
      end
      S_RUN: if (issue) rd_left_d = rd_left_q - PW'(1);
      S_DRAIN: begin
        blk_left_d = blk_left_q - BLK_WIDTH'(1);
        rd_left_d  = rpb_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cfg_q      <= '0;
      nblk_q     <= '0;
      rpb_q      <= '0;
      blk_left_q <= '0;
      rd_left_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      nblk_q     <= nblk_d;
      rpb_q      <= rpb_d;
      blk_left_q <= blk_left_d;
      rd_left_q  <= rd_left_d;
      rd_valid_q <= issue;
    end
  end

  // gen_adr_en stays combinational on stall so the generator holds its address.
  always_comb begin
    gen_config_en   = (state_q == S_CONFIG);
    gen_config_data = cfg_q;
    gen_adr_en      = issue;
    rd_valid        = rd_valid_q;
    bank_release    = (state_q == S_DRAIN);
    busy            = (state_q != S_IDLE);
    done            = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_ifmap_read_sched.sv
// Self-checking bench for ifmap_read_sched: vector table of layer runs with
// a latency scoreboard on rd_valid, plus a hand-written mid-run abort.
module tb_ifmap_read_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] layer_cfg;
  logic [15:0] num_blocks;
  logic        bank_ready;
  logic        stall;
  logic        gen_config_en;
  logic [63:0] gen_config_data;
  logic        gen_adr_en;
  logic        rd_valid;
  logic        bank_release;
  logic        busy;
  logic        done;

  ifmap_read_sched #(.BANK_ADDR_WIDTH(8), .BLK_WIDTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .layer_cfg       (layer_cfg),
    .num_blocks      (num_blocks),
    .bank_ready      (bank_ready),
    .stall           (stall),
    .gen_config_en   (gen_config_en),
    .gen_config_data (gen_config_data),
    .gen_adr_en      (gen_adr_en),
    .rd_valid        (rd_valid),
    .bank_release    (bank_release),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] cfg;
    logic [15:0] nblk;
    int          blo, bhi;      // bank_ready low window (cycles)
    int          slo, shi;      // stall window (cycles)
    int          stall_last;    // also stall once when the last read is due
    int          start_again;   // cycle of a stray start pulse, -1 for none
    int          exp_first;
    int          exp_reads;
    int          exp_rel;
    int          exp_done;
  } vec_t;

  localparam logic [63:0] CFG_A    = 64'h03030303_01050502;
  localparam logic [63:0] CFG_FX0  = 64'h03030003_01050502;
  localparam logic [63:0] CFG_ONES = 64'h01010101_01010101;

  vec_t tv[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int k);
    vec_t   v;
    int     first, reads, rels, done_cyc, done_cnt, cfgs, cfg_cyc, busy_err, limit;
    int     stalled_last;
    longint cfg_seen;
    int     exp_q[$];
    bit     exp_busy;
    v = tv[k];
    first = -1; reads = 0; rels = 0; done_cyc = -1; done_cnt = 0;
    cfgs = 0; cfg_cyc = -1; busy_err = 0; stalled_last = 0; cfg_seen = 0;
    limit = v.exp_done + 30;
    for (int cyc = 0; cyc < limit; cyc++) begin
      start      = (cyc == 0) || (cyc == v.start_again);
      layer_cfg  = (cyc == 0) ? v.cfg : ~v.cfg;
      num_blocks = (cyc == 0) ? v.nblk : 16'd7;
      bank_ready = !(cyc >= v.blo && cyc <= v.bhi);
      stall      = (cyc >= v.slo && cyc <= v.shi);
      if (v.stall_last != 0 && stalled_last == 0 && reads == v.exp_reads - 1) begin
        stall        = 1'b1;
        stalled_last = 1;
      end
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) check($sformatf("v%0d_rd_valid_spurious@%0d", k, cyc), 1, 0);
        else check($sformatf("v%0d_rd_valid_cycle", k), cyc, exp_q.pop_front());
      end
      if (gen_adr_en) begin
        if (first < 0) first = cyc;
        reads++;
        exp_q.push_back(cyc + 1);
      end
      if (gen_config_en) begin
        cfgs++;
        cfg_cyc  = cyc;
        cfg_seen = gen_config_data;
      end
      if (bank_release) rels++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      exp_busy = (cyc >= 1) && (cyc <= v.exp_done);
      if (busy !== exp_busy) busy_err++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stall = 1'b0;
    check($sformatf("v%0d_config_pulses", k), cfgs, 1);
    check($sformatf("v%0d_config_cycle", k), cfg_cyc, 1);
    check($sformatf("v%0d_config_data", k), cfg_seen, v.cfg);
    check($sformatf("v%0d_first_adr_cycle", k), first, v.exp_first);
    check($sformatf("v%0d_read_count", k), reads, v.exp_reads);
    check($sformatf("v%0d_release_count", k), rels, v.exp_rel);
    check($sformatf("v%0d_done_cycle", k), done_cyc, v.exp_done);
    check($sformatf("v%0d_done_pulses", k), done_cnt, 1);
    check($sformatf("v%0d_busy_window_errs", k), busy_err, 0);
    check($sformatf("v%0d_rd_valid_pending", k), exp_q.size(), 0);
  endtask

  task automatic abort_seq();
    int leak;
    leak = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      start      = (cyc == 0);
      layer_cfg  = CFG_A;
      num_blocks = 16'd1;
      bank_ready = 1'b1;
      stall      = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("abort_pre_adr", gen_adr_en, 1);
    check("abort_pre_rd_valid", rd_valid, 1);
    rst_n = 1'b1;
    #1;
    check("abort_config_en", gen_config_en, 0);
    check("abort_config_data", gen_config_data, 0);
    check("abort_adr_en", gen_adr_en, 0);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_release", bank_release, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || bank_release || busy || gen_adr_en) leak++;
      @(posedge clk);
      #1;
    end
    check("abort_quiet_after", leak, 0);
  endtask

  initial begin
    // cfg, nblk, blo, bhi, slo, shi, stall_last, start_again, first, reads, rel, done
    tv[0] = '{CFG_A,    16'd1, -1, -2, -1, -2, 0, 40, 3,  162, 1, 166};
    tv[1] = '{CFG_A,    16'd3, -1, -2, -1, -2, 0, -1, 3,  486, 3, 494};
    tv[2] = '{CFG_A,    16'd1, -1, -2, 10, 14, 1, -1, 3,  162, 1, 172};
    tv[3] = '{CFG_A,    16'd1,  0, 19, -1, -2, 0, -1, 21, 162, 1, 184};
    tv[4] = '{CFG_A,    16'd1, 30, 60, -1, -2, 0, -1, 3,  162, 1, 166};
    tv[5] = '{CFG_FX0,  16'd1, -1, -2, -1, -2, 0, -1, -1, 0,   0, 2};
    tv[6] = '{CFG_A,    16'd0, -1, -2, -1, -2, 0, -1, -1, 0,   0, 2};
    tv[7] = '{CFG_ONES, 16'd2, -1, -2, -1, -2, 0, -1, 3,  2,   2, 8};

    rst_n      = 1'b1;
    start      = 1'b0;
    layer_cfg  = '0;
    num_blocks = '0;
    bank_ready = 1'b0;
    stall      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_config_en", gen_config_en, 0);
    check("reset_config_data", gen_config_data, 0);
    check("reset_adr_en", gen_adr_en, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_release", bank_release, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 8; k++) run_vec(k);
    abort_seq();
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifmap_read_sched.md
# ifmap_read_sched

Layer-level sequencer for the input-feature-map read path. Accepts a layer descriptor and a start pulse, sends the descriptor to the ifmap read-address generator with a one-cycle config strobe, and then gates that generator's `adr_en` for each ifmap block. It also runs a bank-ready/bank-release handshake with the double-buffered ifmap SRAM writer and honours back-pressure from the PE array.

## Interface
- `BANK_ADDR_WIDTH`, default 8: width of every descriptor field.
- `BLK_WIDTH`, default 16: width of the block count.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-high reset (asserted = 1).
- `start` in 1: one-cycle request to run a layer. Sampled only in IDLE.
- `layer_cfg` in 8*BANK_ADDR_WIDTH: packed `{OX0, OY0, FX, FY, STRIDE, IX0, IY0, IC1}`, with OX0 in the MSBs. Latched on an accepted `start`.
- `num_blocks` in BLK_WIDTH: number of ifmap blocks in the layer. Latched on an accepted `start`.
- `bank_ready` in 1: level signal. The read bank holds a full block.
- `stall` in 1: level signal. The PE array cannot accept a read this cycle.
- `gen_config_en` out 1: config strobe to the address generator.
- `gen_config_data` out 8*BANK_ADDR_WIDTH: latched `layer_cfg`.
- `gen_adr_en` out 1: advance strobe to the address generator.
- `rd_valid` out 1: read data from the ifmap bank is valid. It is `gen_adr_en` delayed by one cycle, matching the SRAM read latency.
- `bank_release` out 1: one-cycle pulse. The current bank is finished and the writer may refill it.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the layer completes.

## Operation
- **States:** IDLE, CONFIG, WAIT_BANK, RUN, DRAIN, DONE. All outputs except `gen_adr_en` are decoded from registered state or registered flags.
- **IDLE:**
  - On `start`: latch `layer_cfg` and `num_blocks`, compute `reads_per_block = OX0*OY0*FX*FY*IC1`, go to CONFIG.
  - `reads_per_block` is an unsigned product of width 5*BANK_ADDR_WIDTH, with no truncation.
  - `start` outside IDLE is ignored.
- **CONFIG:** `gen_config_en`=1 for exactly this cycle, with `gen_config_data` valid.
  - If `reads_per_block`==0 or `num_blocks`==0, go to DONE. No bank handshake and no `gen_adr_en`.
  - Otherwise load `blk_left = num_blocks`, `rd_left = reads_per_block`, and go to WAIT_BANK.
- **WAIT_BANK:** when `bank_ready`=1, go to RUN.
- **RUN:**
  - `gen_adr_en = (state==RUN) & ~stall`. This is combinational from `stall`, so the generator holds its address while `stall`=1.
  - Each issued read decrements `rd_left`.
  - When `rd_left`==1 and a read issues, go to DRAIN.
  - STRIDE, IX0 and IY0 are not used for counting. They are only forwarded.
- **DRAIN:** a single cycle.
  - `rd_valid` for the last read appears here.
  - `bank_release`=1 for this cycle.
  - Decrement `blk_left` and reload `rd_left = reads_per_block`.
  - Go to WAIT_BANK if `blk_left` was >1; otherwise go to DONE.
- **Generator reuse:** the generator is not reconfigured between blocks. It wraps to address 0 after its last address, so the next block's first `gen_adr_en` produces address 0.
- **DONE:** `done`=1 for one cycle, then go to IDLE.

## Timing
- **Reset:**
  - State goes to IDLE.
  - `gen_config_en`, `gen_adr_en`, `rd_valid`, `bank_release`, `busy` and `done` are 0.
  - `gen_config_data` and all counters are 0.
- **Reset mid-run:** aborts immediately with the same values. No `done` and no `bank_release` are emitted. The address generator is reset by the same reset network.
- **Start latency:**
  - `start` sampled at edge 0.
  - CONFIG in cycle 1.
  - WAIT_BANK in cycle 2.
  - If `bank_ready` is already high, the first `gen_adr_en` is in cycle 3.
- **Stall-free block:** a block of N reads occupies exactly N RUN cycles, followed by 1 DRAIN cycle.
- **Continuous `bank_ready`:** consecutive blocks have 2 non-issue cycles between them (DRAIN, then WAIT_BANK).
- **`stall` asserted on the last read:** the last read is held. DRAIN is entered only after that read issues.
- **`bank_ready` dropping during RUN:** no effect. It is checked only in WAIT_BANK.
- **`rd_valid`:** equals `gen_adr_en` registered, and is cleared by reset.

## Test plan
- **Single block:** cfg {3,3,3,3,1,5,5,2}, `num_blocks`=1, `bank_ready`=1, `stall`=0, `start` at cycle 0.
  - `gen_config_en` in cycle 1.
  - `gen_adr_en` in cycles 3–164 (162 reads).
  - `bank_release` and the last `rd_valid` in cycle 165.
  - `done` in cycle 166; `busy` low from cycle 167.
  - Attached generator emits 0,1,2,5,6,7,10,…, ending with 49.
- **Multi-block:** same cfg, `num_blocks`=3, `bank_ready` held high.
  - Exactly 486 `gen_adr_en` cycles and 3 `bank_release` pulses.
  - 2-cycle gaps between blocks.
  - Generator address after each release is 0.
- **Stall:** same as the single-block case, with `stall`=1 on cycles 10–14 and on the cycle of the 162nd read.
  - Read count is still 162, with no address skipped or repeated.
  - `done` is delayed by exactly 6 cycles.
- **Bank wait:** `bank_ready`=0 until cycle 20.
  - No `gen_adr_en` before cycle 21.
  - `busy` is high from cycle 1.
- **Zero size:** FX=0 (or `num_blocks`=0).
  - CONFIG in cycle 1, `done` in cycle 2.
  - No `gen_adr_en` and no `bank_release`.
- **Abort and ignore:**
  - `rst_n` asserted at cycle 50 of a run: all outputs 0 in the same cycle, no `done`, and a new `start` afterwards runs normally.
  - `start` pulsed during RUN is ignored.
